// File: rtl/sniffer_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : sniffer_uart_tx
// Brief   : Sniffer output stage. Queues characters from the Saving stage in a
//           small FIFO and sends them on an 8N1 UART line, LSB first.
// Revision: 1.0 - initial release
// ============================================================================
module sniffer_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] data_in,
    input  logic       write,
    output logic       tx,
    output logic       busy,
    output logic       empty,
    output logic       full,
    output logic       overflow
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    localparam int                    c_baud_w    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_baud_w-1:0]   c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]       c_depth     = (ADDR_W + 1)'(FIFO_DEPTH);

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_overflow;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [c_baud_w-1:0] r_baud;
    logic [c_baud_w-1:0] w_baud_next;
    logic [2:0]          r_bit;
    logic [2:0]          w_bit_next;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_next;
    logic                r_tx;
    logic                w_tx_next;
    logic                r_busy;
    logic                w_busy_next;

    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic                w_baud_done;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_depth);
    assign w_pop       = enable && (r_state == c_st_idle) && !w_empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign w_push      = enable && write && (!w_full || w_pop);
    assign w_drop      = enable && write && w_full && !w_pop;
    assign w_baud_done = (r_baud == c_baud_last);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Line level and busy follow the state one cycle late so tx comes
    // straight off a flop.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_tx_next    = r_tx;
        w_busy_next  = r_busy;
        if (enable) begin
            w_busy_next = (r_state != c_st_idle);
            w_baud_next = w_baud_done ? '0 : r_baud + 1'b1;
            case (r_state)
                c_st_idle: begin
                    w_tx_next   = 1'b1;
                    w_baud_next = '0;
                    if (!w_empty) begin
                        w_shift_next = r_mem[r_rd_ptr];
                        w_state_next = c_st_start;
                    end
                end
                c_st_start: begin
                    w_tx_next = 1'b0;
                    if (w_baud_done) begin
                        w_bit_next   = '0;
                        w_state_next = c_st_data;
                    end
                end
                c_st_data: begin
                    w_tx_next = r_shift[0];
                    if (w_baud_done) begin
                        w_shift_next = {1'b0, r_shift[7:1]};
                        w_bit_next   = r_bit + 1'b1;
                        if (r_bit == 3'd7) begin
                            w_state_next = c_st_stop;
                        end
                    end
                end
                c_st_stop: begin
                    w_tx_next = 1'b1;
                    if (w_baud_done) begin
                        w_state_next = c_st_idle;
                    end
                end
                default: begin
                    w_state_next = c_st_idle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            r_busy  <= w_busy_next;
        end
    end

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign empty    = w_empty;
    assign full     = w_full;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sniffer_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_sniffer_uart_tx
// Brief   : Self-checking bench for sniffer_uart_tx against a queue/timer model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sniffer_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] data_in;
    logic       write;
    logic       tx;
    logic       busy;
    logic       empty;
    logic       full;
    logic       overflow;

    sniffer_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .ADDR_W      (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .data_in (data_in),
        .write   (write),
        .tx      (tx),
        .busy    (busy),
        .empty   (empty),
        .full    (full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: FIFO is a queue; a frame is a count of enabled cycles since the pop.
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_log[$];
    logic [7:0] m_cur   = 8'h00;
    bit         m_frame = 1'b0;
    int         m_k     = 0;
    logic       m_tx    = 1'b1;
    logic       m_busy  = 1'b0;
    logic       m_ovf   = 1'b0;

    function automatic logic line_level(input logic [7:0] c, input int k);
        int b;
        b = (k - 1) / CPB;
        if (b == 0) return 1'b0;
        if (b >= 9) return 1'b1;
        return c[b-1];
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete();
                exp_q.delete();
                m_frame = 1'b0;
                m_k     = 0;
                m_tx    = 1'b1;
                m_busy  = 1'b0;
                m_ovf   = 1'b0;
            end else if (enable) begin
                int sz;
                bit popd;
                sz   = m_q.size();
                popd = 1'b0;
                if (m_frame) begin
                    m_k++;
                    m_tx   = line_level(m_cur, m_k);
                    m_busy = 1'b1;
                    if (m_k == FRAME) m_frame = 1'b0;
                end else begin
                    m_tx   = 1'b1;
                    m_busy = 1'b0;
                    if (sz > 0) begin
                        m_cur   = m_q.pop_front();
                        exp_q.push_back(m_cur);
                        m_frame = 1'b1;
                        m_k     = 0;
                        popd    = 1'b1;
                    end
                end
                if (write) begin
                    if (sz < DEPTH || popd) m_q.push_back(data_in);
                    else                    m_ovf = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                chk("tx",       tx,       m_tx);
                chk("busy",     busy,     m_busy);
                chk("empty",    empty,    m_q.size() == 0);
                chk("full",     full,     m_q.size() == DEPTH);
                chk("overflow", overflow, m_ovf);
            end
        end
    end

    // Line receiver: counts only enabled cycles so frozen bits stretch cleanly.
    bit         rx_busy = 1'b0;
    int         rx_n    = 0;
    logic [7:0] rx_byte = 8'h00;
    initial begin
        forever begin
            logic en_s;
            @(posedge clk);
            en_s = enable;
            #1;
            if (rst) begin
                rx_busy = 1'b0;
            end else if (!rx_busy) begin
                if (en_s && tx === 1'b0) begin
                    rx_busy = 1'b1;
                    rx_n    = 0;
                end
            end else if (en_s) begin
                rx_n++;
                if (rx_n % CPB == CPB / 2) begin
                    int b;
                    b = rx_n / CPB;
                    if (b == 0) begin
                        if (tx !== 1'b0) rx_busy = 1'b0;
                    end else if (b <= 8) begin
                        rx_byte[b-1] = tx;
                    end else begin
                        chk("rx_stop", tx, 1'b1);
                        rx_log.push_back(rx_byte);
                        if (exp_q.size() == 0) chk("rx_unexpected", rx_byte, 32'hFFFF_FFFF);
                        else                   chk("rx_byte", rx_byte, exp_q.pop_front());
                        rx_busy = 1'b0;
                    end
                end
            end
        end
    end

    int busy_run  = 0;
    int busy_last = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (busy === 1'b1) busy_run++;
            else if (busy_run > 0) begin
                busy_last = busy_run;
                busy_run  = 0;
            end
        end
    end

    task automatic wait_k(input int kv);
        int n;
        n = 0;
        while (!(m_frame && m_k == kv) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("timeout_wait_k", 0, 1);
    endtask

    task automatic wait_pop_next();
        int n;
        n = 0;
        while (!(!m_frame && m_q.size() > 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("timeout_wait_pop", 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(!m_frame && m_q.size() == 0 && !rx_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("timeout_wait_idle", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic burst(input logic [7:0] first, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            data_in = first + 8'(i);
            write   = 1'b1;
            @(negedge clk);
        end
        write = 1'b0;
    endtask

    int         t1_pat [10] = '{0, 1, 1, 1, 0, 1, 1, 0, 0, 1};
    logic [7:0] t2_str [8]  = '{8'h61, 8'h37, 8'h32, 8'h39, 8'h20, 8'h38, 8'h39, 8'h32};
    int         base;

    initial begin
        rst     = 1'b1;
        enable  = 1'b1;
        write   = 1'b0;
        data_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx",       tx,       1);
        chk("rst_busy",     busy,     0);
        chk("rst_empty",    empty,    1);
        chk("rst_full",     full,     0);
        chk("rst_overflow", overflow, 0);
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Single byte: latency, bit pattern, busy length.
        base    = rx_log.size();
        data_in = 8'h37;
        write   = 1'b1;
        @(negedge clk);
        write = 1'b0;
        @(posedge clk); #1;
        chk("t1_tx_edge1",    tx,    1);
        chk("t1_empty_edge1", empty, 1);
        @(posedge clk); #1;
        chk("t1_bit0", tx, t1_pat[0]);
        for (int b = 1; b < 10; b++) begin
            repeat (CPB) @(posedge clk);
            #1;
            chk("t1_bit", tx, t1_pat[b]);
        end
        wait_idle();
        chk("t1_busy_len", busy_last, 40);
        chk("t1_rx_cnt",   rx_log.size(), base + 1);
        if (rx_log.size() > base) chk("t1_rx", rx_log[base], 8'h37);

        // Character string with gaps.
        base = rx_log.size();
        for (int i = 0; i < 8; i++) begin
            data_in = t2_str[i];
            write   = 1'b1;
            @(negedge clk);
            write = 1'b0;
            repeat (34) @(negedge clk);
        end
        wait_idle();
        chk("t2_rx_cnt", rx_log.size(), base + 8);
        for (int i = 0; i < 8; i++) begin
            if (rx_log.size() > base + i) chk("t2_rx", rx_log[base+i], t2_str[i]);
        end
        chk("t2_overflow", overflow, 0);

        // Six-byte burst into a four-deep FIFO.
        base = rx_log.size();
        for (int i = 0; i < 6; i++) begin
            data_in = 8'h31 + 8'(i);
            write   = 1'b1;
            if (i == 5) chk("t3_full_before_6th", full, 1);
            @(negedge clk);
        end
        write = 1'b0;
        chk("t3_overflow", overflow, 1);
        chk("t3_full",     full,     1);
        wait_idle();
        chk("t3_rx_cnt", rx_log.size(), base + 5);
        for (int i = 0; i < 5; i++) begin
            if (rx_log.size() > base + i) chk("t3_rx", rx_log[base+i], 8'h31 + 8'(i));
        end
        chk("t3_overflow_sticky", overflow, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t3_overflow_cleared", overflow, 0);

        // Write on the exact pop cycle of a full FIFO.
        base = rx_log.size();
        burst(8'h41, 5);
        chk("t4_full_filled", full, 1);
        wait_pop_next();
        data_in = 8'h46;
        write   = 1'b1;
        @(negedge clk);
        write = 1'b0;
        chk("t4_full_after", full,     1);
        chk("t4_ovf_after",  overflow, 0);
        wait_idle();
        chk("t4_rx_cnt", rx_log.size(), base + 6);
        for (int i = 0; i < 6; i++) begin
            if (rx_log.size() > base + i) chk("t4_rx", rx_log[base+i], 8'h41 + 8'(i));
        end

        // Freeze during data bit 3.
        base = rx_log.size();
        burst(8'hA5, 1);
        wait_k(18);
        enable  = 1'b0;
        write   = 1'b1;
        data_in = 8'h77;
        repeat (5) @(negedge clk);
        chk("t5_tx_hold",   tx,    0);
        chk("t5_busy_hold", busy,  1);
        chk("t5_empty",     empty, 1);
        repeat (5) @(negedge clk);
        enable = 1'b1;
        write  = 1'b0;
        wait_idle();
        chk("t5_rx_cnt", rx_log.size(), base + 1);
        if (rx_log.size() > base) chk("t5_rx", rx_log[base], 8'hA5);

        // Asynchronous reset mid-frame with bytes queued.
        burst(8'h61, 4);
        wait_k(20);
        @(posedge clk);
        #2;
        chk("t6_tx_pre", tx, 0);
        rst = 1'b1;
        #1;
        chk("t6_tx",       tx,       1);
        chk("t6_busy",     busy,     0);
        chk("t6_empty",    empty,    1);
        chk("t6_full",     full,     0);
        chk("t6_overflow", overflow, 0);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        base = rx_log.size();
        repeat (150) @(negedge clk);
        chk("t6_no_frames", rx_log.size(), base);
        chk("t6_tx_idle",   tx,            1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
